// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, bus-source encodings,
// FSM state type and strobe bundle. Defining CTRL_SHIFT_EN makes sll/srl ALU operations.
package ctrl_pkg;

  localparam int unsigned OP_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_MV   = 4'h0;
  localparam logic [OP_BITS-1:0] OP_MVI  = 4'h1;
  localparam logic [OP_BITS-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_BITS-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_BITS-1:0] OP_LD   = 4'h4;
  localparam logic [OP_BITS-1:0] OP_ST   = 4'h5;
  localparam logic [OP_BITS-1:0] OP_MVNZ = 4'h6;
  localparam logic [OP_BITS-1:0] OP_AND  = 4'h7;
  localparam logic [OP_BITS-1:0] OP_SLT  = 4'h8;
  localparam logic [OP_BITS-1:0] OP_SLL  = 4'h9;
  localparam logic [OP_BITS-1:0] OP_SRL  = 4'hA;
  localparam logic [OP_BITS-1:0] OP_HALT = 4'hB;

  localparam logic [1:0] MUX_REG = 2'b00;
  localparam logic [1:0] MUX_DIN = 2'b01;
  localparam logic [1:0] MUX_G   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_T1,
    S_T2,
    S_T3,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       reg_sel;
    logic       ir_write;
    logic       a_write;
    logic       g_write;
    logic       addr_write;
    logic       dout_write;
    logic       mem_write;
    logic       din_sel;
    logic       incr_pc;
    logic [1:0] mux_sel;
    logic       done;
  } strobe_t;

  // Opcodes that run the three-step A/G/writeback ALU sequence
  function automatic logic is_alu_op(input logic [OP_BITS-1:0] op);
    logic res;
    res = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_SLT: res = 1'b1;
`ifdef CTRL_SHIFT_EN
      OP_SLL, OP_SRL: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: maps FSM state plus the latched opcode to datapath controls.
// Honours CTRL_SHIFT_EN through ctrl_pkg::is_alu_op.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned REG_AW   = 3
) (
  input  state_t              state,
  input  logic [OPCODE_W-1:0] op,
  input  logic [OPCODE_W-1:0] fetch_op,
  input  logic [REG_AW-1:0]   reg_x,
  input  logic                move_enable,
  output strobe_t             strobes,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                halt_next,
  output logic                undef
);

  logic [OP_BITS-1:0] op4;
  logic               op_fits;

  // Opcodes wider than the table only decode when the extra bits are zero
  assign op4     = OP_BITS'(op);
  assign op_fits = (op >> OP_BITS) == '0;

  always_comb begin
    strobes         = '0;
    strobes.mux_sel = MUX_REG;
    alu_op          = '0;
    halt_next       = 1'b0;
    undef           = 1'b0;

    case (state)
      S_FETCH: begin
        strobes.ir_write = 1'b1;
        strobes.incr_pc  = (fetch_op == OPCODE_W'(OP_MVI));
      end
      S_T1: begin
        if (!op_fits) begin
          undef        = 1'b1;
          halt_next    = 1'b1;
          strobes.done = 1'b1;
        end else begin
          case (op4)
            OP_MV: begin
              strobes.reg_sel   = 1'b1;
              strobes.reg_write = 1'b1;
              strobes.done      = 1'b1;
            end
            OP_MVI: begin
              strobes.mux_sel   = MUX_DIN;
              strobes.reg_write = 1'b1;
              strobes.done      = 1'b1;
            end
            OP_MVNZ: begin
              strobes.reg_sel   = 1'b1;
              strobes.reg_write = move_enable;
              strobes.done      = 1'b1;
            end
            OP_LD, OP_ST: begin
              strobes.reg_sel    = 1'b1;
              strobes.addr_write = 1'b1;
            end
            OP_HALT: begin
              halt_next    = 1'b1;
              strobes.done = 1'b1;
            end
            default: begin
              if (is_alu_op(op4)) begin
                strobes.a_write = 1'b1;
              end else begin
                undef        = 1'b1;
                halt_next    = 1'b1;
                strobes.done = 1'b1;
              end
            end
          endcase
        end
      end
      S_T2: begin
        if (op_fits && op4 == OP_LD) begin
          strobes.mux_sel   = MUX_DIN;
          strobes.din_sel   = 1'b1;
          strobes.reg_write = 1'b1;
          strobes.done      = 1'b1;
        end else if (op_fits && op4 == OP_ST) begin
          strobes.dout_write = 1'b1;
          strobes.mem_write  = 1'b1;
          strobes.done       = 1'b1;
        end else if (op_fits && is_alu_op(op4)) begin
          strobes.reg_sel = 1'b1;
          strobes.g_write = 1'b1;
          alu_op          = op;
        end
      end
      S_T3: begin
        if (op_fits && is_alu_op(op4)) begin
          strobes.mux_sel   = MUX_G;
          strobes.reg_write = 1'b1;
          strobes.done      = 1'b1;
        end
      end
      default: ;
    endcase

    // A write into the PC register replaces the normal PC increment
    if (strobes.done && !halt_next) begin
      strobes.incr_pc = !(strobes.reg_write && reg_x == {REG_AW{1'b1}});
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FSM, instruction register and sticky illegal flag around ctrl_decode.
// Build with CTRL_SHIFT_EN to execute sll/srl; otherwise they halt as illegal.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned REG_AW   = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         run,
  input  logic [OPCODE_W+2*REG_AW-1:0] instr,
  input  logic                         move_enable,
  output logic [REG_AW-1:0]            reg_x,
  output logic [REG_AW-1:0]            reg_y,
  output logic [1:0]                   mux_sel,
  output logic                         reg_write,
  output logic                         reg_sel,
  output logic                         ir_write,
  output logic                         a_write,
  output logic                         g_write,
  output logic                         addr_write,
  output logic                         dout_write,
  output logic                         mem_write,
  output logic                         din_sel,
  output logic                         incr_pc,
  output logic [OPCODE_W-1:0]          alu_op,
  output logic                         done,
  output logic                         busy,
  output logic                         halted,
  output logic                         illegal
);

  localparam int unsigned INSTR_W = OPCODE_W + 2 * REG_AW;

  state_t              state;
  logic [INSTR_W-1:0]  ir;
  strobe_t             dec_strobes;
  strobe_t             strobes;
  logic [OPCODE_W-1:0] dec_alu_op;
  logic                halt_next;
  logic                undef;

  ctrl_decode #(
    .OPCODE_W(OPCODE_W),
    .REG_AW  (REG_AW)
  ) u_decode (
    .state      (state),
    .op         (ir[INSTR_W-1 -: OPCODE_W]),
    .fetch_op   (instr[INSTR_W-1 -: OPCODE_W]),
    .reg_x      (ir[2*REG_AW-1:REG_AW]),
    .move_enable(move_enable),
    .strobes    (dec_strobes),
    .alu_op     (dec_alu_op),
    .halt_next  (halt_next),
    .undef      (undef)
  );

  // Sequencer state, IR capture and sticky illegal flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_FETCH;
        S_FETCH: begin
          ir    <= instr;
          state <= S_T1;
        end
        S_T1, S_T2, S_T3: begin
          if (dec_strobes.done) begin
            if (undef) illegal <= 1'b1;
            if (halt_next)  state <= S_HALT;
            else if (run)   state <= S_FETCH;
            else            state <= S_IDLE;
          end else begin
            state <= (state == S_T1) ? S_T2 : S_T3;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Suppress strobes while reset is sampled so no write lands on the reset edge
  assign strobes = reset ? '0 : dec_strobes;
  assign alu_op  = reset ? '0 : dec_alu_op;

  assign reg_x      = ir[2*REG_AW-1:REG_AW];
  assign reg_y      = ir[REG_AW-1:0];
  assign mux_sel    = strobes.mux_sel;
  assign reg_write  = strobes.reg_write;
  assign reg_sel    = strobes.reg_sel;
  assign ir_write   = strobes.ir_write;
  assign a_write    = strobes.a_write;
  assign g_write    = strobes.g_write;
  assign addr_write = strobes.addr_write;
  assign dout_write = strobes.dout_write;
  assign mem_write  = strobes.mem_write;
  assign din_sel    = strobes.din_sel;
  assign incr_pc    = strobes.incr_pc;
  assign done       = strobes.done;
  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; shift opcodes checked per CTRL_SHIFT_EN.
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       reset, run, move_enable;
  logic [9:0] instr;
  logic [2:0] reg_x, reg_y;
  logic [1:0] mux_sel;
  logic       reg_write, reg_sel, ir_write, a_write, g_write, addr_write;
  logic       dout_write, mem_write, din_sel, incr_pc, done, busy, halted, illegal;
  logic [3:0] alu_op;

  int checks = 0;
  int errors = 0;

  // Strobe vector bit positions: {rw,rs,iw,aw,gw,adw,dw,mw,ds,ip,mux[1:0],dn}
  localparam logic [12:0] RW  = 13'h1000, RS = 13'h0800, IW = 13'h0400, AW = 13'h0200;
  localparam logic [12:0] GW  = 13'h0100, ADW = 13'h0080, DW = 13'h0040, MW = 13'h0020;
  localparam logic [12:0] DS  = 13'h0010, IP = 13'h0008, MXG = 13'h0004, MXD = 13'h0002;
  localparam logic [12:0] DN  = 13'h0001, NONE = 13'h0000;

  control_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .move_enable(move_enable),
    .reg_x(reg_x), .reg_y(reg_y), .mux_sel(mux_sel), .reg_write(reg_write),
    .reg_sel(reg_sel), .ir_write(ir_write), .a_write(a_write), .g_write(g_write),
    .addr_write(addr_write), .dout_write(dout_write), .mem_write(mem_write),
    .din_sel(din_sel), .incr_pc(incr_pc), .alu_op(alu_op), .done(done),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] obs();
    return {reg_write, reg_sel, ir_write, a_write, g_write, addr_write, dout_write,
            mem_write, din_sel, incr_pc, mux_sel, done};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; move_enable = 1'b0; instr = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({obs(), busy, halted, illegal, reg_x, reg_y, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_state: got strobes=%h busy=%b halted=%b illegal=%b exp all zero",
               obs(), busy, halted, illegal);
    end
  endtask

  task automatic test_add();
    run = 1'b1; instr = {4'b0010, 3'd1, 3'd2};
    tick();
    checks++;
    if (obs() !== IW || busy !== 1'b1) begin
      errors++; $display("FAIL add_fetch: got %h busy=%b exp %h busy=1", obs(), busy, IW);
    end
    tick();
    run = 1'b0;
    checks++;
    if (obs() !== AW || reg_x !== 3'd1 || reg_y !== 3'd2 || alu_op !== 4'd0) begin
      errors++; $display("FAIL add_t1: got %h x=%0d y=%0d op=%h exp %h x=1 y=2 op=0", obs(), reg_x, reg_y, alu_op, AW);
    end
    tick();
    checks++;
    if (obs() !== (RS | GW) || alu_op !== 4'b0010) begin
      errors++; $display("FAIL add_t2: got %h op=%h exp %h op=2", obs(), alu_op, RS | GW);
    end
    tick();
    checks++;
    if (obs() !== (RW | MXG | IP | DN) || alu_op !== 4'd0) begin
      errors++; $display("FAIL add_t3: got %h op=%h exp %h op=0", obs(), alu_op, RW | MXG | IP | DN);
    end
    tick();
    checks++;
    if (obs() !== NONE || busy !== 1'b0) begin
      errors++; $display("FAIL add_idle: got %h busy=%b exp 0 busy=0", obs(), busy);
    end
  endtask

  task automatic test_mv();
    run = 1'b1; instr = {4'b0000, 3'd7, 3'd3};
    tick();
    tick();
    instr = {4'b0000, 3'd1, 3'd3};
    checks++;
    if (obs() !== (RW | RS | DN) || reg_x !== 3'd7) begin
      errors++; $display("FAIL mv_pc_t1: got %h x=%0d exp %h x=7", obs(), reg_x, RW | RS | DN);
    end
    tick();
    checks++;
    if (obs() !== IW) begin
      errors++; $display("FAIL mv_refetch: got %h exp %h", obs(), IW);
    end
    tick();
    run = 1'b0;
    checks++;
    if (obs() !== (RW | RS | IP | DN)) begin
      errors++; $display("FAIL mv_r1_t1: got %h exp %h", obs(), RW | RS | IP | DN);
    end
    tick();
  endtask

  task automatic test_mvi();
    run = 1'b1; instr = {4'b0001, 3'd2, 3'd0};
    tick();
    checks++;
    if (obs() !== (IW | IP)) begin
      errors++; $display("FAIL mvi_fetch: got %h exp %h", obs(), IW | IP);
    end
    tick();
    run = 1'b0;
    checks++;
    if (obs() !== (MXD | RW | IP | DN)) begin
      errors++; $display("FAIL mvi_t1: got %h exp %h", obs(), MXD | RW | IP | DN);
    end
    tick();
  endtask

  task automatic test_mvnz();
    run = 1'b1; move_enable = 1'b0; instr = {4'b0110, 3'd1, 3'd2};
    tick();
    tick();
    instr = {4'b0110, 3'd7, 3'd2};
    checks++;
    if (obs() !== (RS | IP | DN)) begin
      errors++; $display("FAIL mvnz_off: got %h exp %h", obs(), RS | IP | DN);
    end
    tick();
    move_enable = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (obs() !== (RW | RS | DN)) begin
      errors++; $display("FAIL mvnz_on_pc: got %h exp %h", obs(), RW | RS | DN);
    end
    tick();
    move_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    run = 1'b1; instr = {4'b0100, 3'd3, 3'd5};
    tick();
    tick();
    instr = {4'b0101, 3'd4, 3'd6};
    checks++;
    if (obs() !== (RS | ADW)) begin
      errors++; $display("FAIL ld_t1: got %h exp %h", obs(), RS | ADW);
    end
    tick();
    checks++;
    if (obs() !== (MXD | DS | RW | IP | DN)) begin
      errors++; $display("FAIL ld_t2: got %h exp %h", obs(), MXD | DS | RW | IP | DN);
    end
    tick();
    checks++;
    if (obs() !== IW || busy !== 1'b1) begin
      errors++; $display("FAIL st_fetch: got %h busy=%b exp %h busy=1", obs(), busy, IW);
    end
    tick();
    checks++;
    if (obs() !== (RS | ADW)) begin
      errors++; $display("FAIL st_t1: got %h exp %h", obs(), RS | ADW);
    end
    tick();
    run = 1'b0;
    checks++;
    if (obs() !== (DW | MW | IP | DN)) begin
      errors++; $display("FAIL st_t2: got %h exp %h", obs(), DW | MW | IP | DN);
    end
    tick();
    checks++;
    if (obs() !== NONE || busy !== 1'b0) begin
      errors++; $display("FAIL st_idle: got %h busy=%b exp 0 busy=0", obs(), busy);
    end
  endtask

  task automatic test_reset_mid();
    run = 1'b1; instr = {4'b0010, 3'd5, 3'd6};
    tick(); tick(); tick();
    checks++;
    if (obs() !== (RS | GW)) begin
      errors++; $display("FAIL rst_mid_t2: got %h exp %h", obs(), RS | GW);
    end
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if (obs() !== NONE || busy !== 1'b0 || reg_x !== 3'd0 || alu_op !== 4'd0) begin
      errors++; $display("FAIL rst_mid_after: got %h busy=%b x=%0d op=%h exp all zero", obs(), busy, reg_x, alu_op);
    end
    tick();
  endtask

  task automatic test_halt();
    run = 1'b1; instr = {4'b1011, 3'd0, 3'd0};
    tick(); tick();
    checks++;
    if (done !== 1'b1 || reg_write !== 1'b0) begin
      errors++; $display("FAIL halt_t1: got done=%b rw=%b exp done=1 rw=0", done, reg_write);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || illegal !== 1'b0 || busy !== 1'b0 || obs() !== NONE) begin
      errors++; $display("FAIL halt_state: got halted=%b illegal=%b busy=%b strobes=%h exp 1 0 0 0", halted, illegal, busy, obs());
    end
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_illegal();
    run = 1'b1; instr = {4'b1111, 3'd0, 3'd0};
    tick(); tick();
    checks++;
    if (obs() !== DN) begin
      errors++; $display("FAIL illegal_t1: got %h exp %h", obs(), DN);
    end
    tick();
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1 || obs() !== NONE) begin
      errors++; $display("FAIL illegal_halt: got illegal=%b halted=%b strobes=%h exp 1 1 0", illegal, halted, obs());
    end
    instr = {4'b0001, 3'd1, 3'd0};
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      tick();
      checks++;
      if (halted !== 1'b1 || illegal !== 1'b1 || obs() !== NONE) begin
        errors++; $display("FAIL illegal_hold%0d: got halted=%b illegal=%b strobes=%h exp 1 1 0", i, halted, illegal, obs());
      end
    end
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if (halted !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_reset: got halted=%b illegal=%b busy=%b exp 0 0 0", halted, illegal, busy);
    end
  endtask

  task automatic test_shift();
    run = 1'b1; instr = {4'b1001, 3'd1, 3'd2};
    tick(); tick();
`ifdef CTRL_SHIFT_EN
    run = 1'b0;
    checks++;
    if (obs() !== AW) begin
      errors++; $display("FAIL sll_t1: got %h exp %h", obs(), AW);
    end
    tick();
    checks++;
    if (obs() !== (RS | GW) || alu_op !== 4'b1001) begin
      errors++; $display("FAIL sll_t2: got %h op=%h exp %h op=9", obs(), alu_op, RS | GW);
    end
    tick();
    checks++;
    if (obs() !== (RW | MXG | IP | DN)) begin
      errors++; $display("FAIL sll_t3: got %h exp %h", obs(), RW | MXG | IP | DN);
    end
    tick();
`else
    checks++;
    if (obs() !== DN) begin
      errors++; $display("FAIL sll_undef_t1: got %h exp %h", obs(), DN);
    end
    tick();
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1) begin
      errors++; $display("FAIL sll_undef: got illegal=%b halted=%b exp 1 1", illegal, halted);
    end
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_mv();
    test_mvi();
    test_mvnz();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    test_illegal();
    test_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 4: opcode field width.
REQ-002 Parameter REG_AW, default 3: register index width; PC index is 2**REG_AW-1; instruction width INSTR_W = OPCODE_W+2*REG_AW.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  level; start/continue execution.
REQ-006 instr  in  INSTR_W  instruction word from fetch bus, sampled in FETCH.
REQ-007 move_enable  in  1  G-nonzero condition for mvnz.
REQ-008 reg_x, reg_y  out  REG_AW each  latched IR fields [2*REG_AW-1:REG_AW], [REG_AW-1:0].
REQ-009 mux_sel  out  2  bus source: 00 regbank, 01 DIN, 10 G.
REQ-010 reg_write, reg_sel, ir_write, a_write, g_write, addr_write, dout_write, mem_write, din_sel, incr_pc  out  1 each  datapath strobes (reg_sel 0=Rx, 1=Ry; din_sel 0=ROM, 1=RAM).
REQ-011 alu_op  out  OPCODE_W  ALU operation.
REQ-012 done  out  1  one-cycle pulse in final step of each instruction.
REQ-013 busy  out  1  high in any state except IDLE and HALT.
REQ-014 halted  out  1  high in HALT; illegal  out  1  sticky, set on undefined opcode.

Function
REQ-015 FSM states IDLE, FETCH, T1, T2, T3, HALT; state and internal IR are the only state besides the illegal flag; strobes are decoded combinationally from state and IR.
REQ-016 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-017 FETCH: ir_write=1, din_sel=0; IR loads instr at this edge; incr_pc=1 only when instr opcode is mvi; -> T1.
REQ-018 Opcodes: 0000 mv, 0001 mvi, 0010 add, 0011 sub, 0100 ld, 0101 st, 0110 mvnz, 0111 and, 1000 slt, 1001 sll, 1010 srl, 1011 halt; others undefined.
REQ-019 mv T1: reg_sel=1, mux_sel=00, reg_write=1; final.
REQ-020 mvi T1: mux_sel=01, reg_write=1; final.
REQ-021 mvnz T1: reg_sel=1, mux_sel=00, reg_write=move_enable; final.
REQ-022 ALU ops: T1 reg_sel=0, a_write=1; T2 reg_sel=1, g_write=1, alu_op=opcode; T3 mux_sel=10, reg_sel=0, reg_write=1; final. alu_op=0 in all other cycles.
REQ-023 ld: T1 reg_sel=1, addr_write=1; T2 mux_sel=01, din_sel=1, reg_write=1; final.
REQ-024 st: T1 reg_sel=1, addr_write=1; T2 reg_sel=0, dout_write=1, mem_write=1; final.
REQ-025 Final step asserts done=1 and incr_pc=1, except incr_pc=0 when reg_write=1 and reg_x=PC index.
REQ-026 Latency FETCH->done: mv/mvi/mvnz 2 cycles, ld/st 3, ALU 4.
REQ-027 After final step: run=1 -> FETCH (back-to-back, no bubble); run=0 -> IDLE.
REQ-028 run deasserted mid-instruction is ignored; instruction completes.
REQ-029 halt in T1: done=1, -> HALT; HALT holds all strobes 0 regardless of run until reset.
REQ-030 Undefined opcode in T1: illegal set, done=1, no strobes, -> HALT.

Reset
REQ-031 reset=1 at any edge, including mid-instruction: state IDLE, IR 0, illegal 0; all outputs 0 the following cycle; no pending write completes.

Configuration
REQ-032 Macro CTRL_SHIFT_EN: defined -> sll/srl execute per REQ-022; undefined -> 1001/1010 treated as undefined per REQ-030; all other behaviour identical.

Structure
REQ-033 Shared package ctrl_pkg holds opcode constants, mux_sel encodings, and the state enum typedef.
REQ-034 One sub-module, ctrl_decode: combinational state+IR to strobe decoder; top holds FSM, IR, and illegal flag.

Verification
REQ-035 Reset, run=1, instr=0010_001_010 (add R1,R2): a_write at T1, g_write with alu_op=0010 at T2, reg_write with mux_sel=10 at T3, done at T3 only.
REQ-036 mv R7,R3 (0000_111_011): reg_write=1, incr_pc=0, done=1 in T1; mv R1,R3 gives incr_pc=1.
REQ-037 mvnz with move_enable=0 -> reg_write=0, incr_pc=1; with move_enable=1 and reg_x=7 -> reg_write=1, incr_pc=0.
REQ-038 Back-to-back ld then st with run held 1: FETCH immediately follows each done; ld T2 din_sel=1; st T2 mem_write=1.
REQ-039 Opcode 1111 -> illegal=1, halted=1, no further strobes; run toggled -> still halted; reset -> IDLE, illegal=0.
REQ-040 reset asserted during add T2 -> next cycle all strobes 0, state IDLE; build without CTRL_SHIFT_EN: 1001 -> illegal=1.
